// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run control for the MIPS core on the SYS_CLK domain.
// Instead of gating the clock, the core receives a one-cycle enable (CPU_EN).
// Features: four selectable step rates, halt, single-step, PC breakpoint,
// heartbeat and a count of issued ticks.
// Optional build macro RUN_CTRL_DEBOUNCE_EN adds a debounce filter on the
// synchronised STEP button. Without it, DEB_CYCLES has no effect.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | divider counting; a tick is issued at each terminal count
// HALTED | no ticks; waiting for a step event or for HALT to drop
// STEP   | one-cycle state; the single-step tick is issued on leaving it
// BREAK  | PC reached the breakpoint; waiting for a step or BP_EN=0
module cpu_run_ctrl #(
    parameter int CNT_W      = 27,
    parameter int DIV_0      = 100000000,
    parameter int DIV_1      = 25000000,
    parameter int DIV_2      = 1000000,
    parameter int DIV_3      = 1000,
    parameter int PC_W       = 7,
    parameter int ICNT_W     = 16,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic              HALT,
    input  logic              STEP,
    input  logic [1:0]        RATE_SEL,
    input  logic              BP_EN,
    input  logic [PC_W-1:0]   BP_ADDR,
    input  logic [PC_W-1:0]   PC,
    output logic              CPU_EN,
    output logic              HB,
    output logic [1:0]        STATE,
    output logic [ICNT_W-1:0] ICNT
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_HALTED = 2'b01,
        S_STEP   = 2'b10,
        S_BREAK  = 2'b11
    } state_t;

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    // The debounce window length only matters when the filter is built in.
    localparam int DEB_LEN = DEB_ON ? DEB_CYCLES : 1;
    localparam int DEB_W   = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_tc;
    logic [1:0]       rate_q;
    logic             rate_chg;
    logic             div_hit;
    logic             bp_hit;

    logic step_s1;
    logic step_s2;
    logic step_lvl;
    logic step_lvl_d;
    logic step_evt;

    // Terminal count for the currently selected rate.
    always_comb begin
        div_tc = CNT_W'(DIV_0 - 1);
        case (RATE_SEL)
            2'd0: div_tc = CNT_W'(DIV_0 - 1);
            2'd1: div_tc = CNT_W'(DIV_1 - 1);
            2'd2: div_tc = CNT_W'(DIV_2 - 1);
            2'd3: div_tc = CNT_W'(DIV_3 - 1);
            default: div_tc = CNT_W'(DIV_0 - 1);
        endcase
    end

    assign rate_chg = (RATE_SEL != rate_q);
    assign div_hit  = (div_cnt == div_tc);
    assign bp_hit   = BP_EN && (PC == BP_ADDR);

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
        end else begin
            step_s1 <= STEP;
            step_s2 <= step_s1;
        end
    end

    generate
        if (DEB_ON) begin : g_deb
            logic [DEB_W-1:0] deb_cnt;
            logic             deb_lvl;

            // Debounce: the level follows the input only after it has differed
            // for DEB_LEN consecutive cycles; any return to the old level restarts the window.
            always_ff @(posedge SYS_CLK) begin
                if (RST) begin
                    deb_cnt <= DEB_W'(DEB_LEN - 1);
                    deb_lvl <= 1'b0;
                end else if (step_s2 == deb_lvl) begin
                    deb_cnt <= DEB_W'(DEB_LEN - 1);
                end else if (deb_cnt == '0) begin
                    deb_lvl <= step_s2;
                    deb_cnt <= DEB_W'(DEB_LEN - 1);
                end else begin
                    deb_cnt <= deb_cnt - 1'b1;
                end
            end

            assign step_lvl = deb_lvl;
        end else begin : g_raw
            assign step_lvl = step_s2;
        end
    endgenerate

    // Delayed copy of the step level, used for rising-edge detection.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            step_lvl_d <= 1'b0;
        end else begin
            step_lvl_d <= step_lvl;
        end
    end

    // The edge event is combinational, so the FSM acts on it on the third
    // edge after a clean STEP rise.
    assign step_evt = step_lvl & ~step_lvl_d;

    // Run-control FSM with the divider and registered tick, heartbeat and tick count.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state   <= S_RUN;
            div_cnt <= '0;
            rate_q  <= '0;
            CPU_EN  <= 1'b0;
            HB      <= 1'b0;
            ICNT    <= '0;
        end else begin
            rate_q <= RATE_SEL;
            CPU_EN <= 1'b0;
            case (state)
                S_RUN: begin
                    if (HALT) begin
                        state <= S_HALTED;
                    end else if (rate_chg) begin
                        div_cnt <= '0;
                    end else if (div_hit) begin
                        div_cnt <= '0;
                        if (bp_hit) begin
                            state <= S_BREAK;
                        end else begin
                            CPU_EN <= 1'b1;
                            HB     <= ~HB;
                            ICNT   <= ICNT + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HALTED: begin
                    if (step_evt) begin
                        state <= S_STEP;
                    end else if (!HALT) begin
                        state   <= S_RUN;
                        div_cnt <= '0;
                    end
                end
                S_STEP: begin
                    state  <= S_HALTED;
                    CPU_EN <= 1'b1;
                    HB     <= ~HB;
                    ICNT   <= ICNT + 1'b1;
                end
                S_BREAK: begin
                    if (step_evt) begin
                        state <= S_STEP;
                    end else if (!BP_EN) begin
                        if (HALT) begin
                            state <= S_HALTED;
                        end else begin
                            state   <= S_RUN;
                            div_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state   <= S_RUN;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl using small dividers (4/6/8/10).
// Expected ticks are queued with their cycle number, tick count and heartbeat.
// They are checked when the DUT raises CPU_EN.
module tb_cpu_run_ctrl;

    localparam int PC_W   = 7;
    localparam int ICNT_W = 16;
`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int STEP_LAT = 9;
`else
    localparam int STEP_LAT = 4;
`endif

    logic              SYS_CLK = 1'b0;
    logic              RST;
    logic              HALT;
    logic              STEP;
    logic [1:0]        RATE_SEL;
    logic              BP_EN;
    logic [PC_W-1:0]   BP_ADDR;
    logic [PC_W-1:0]   PC;
    logic              CPU_EN;
    logic              HB;
    logic [1:0]        STATE;
    logic [ICNT_W-1:0] ICNT;

    cpu_run_ctrl #(
        .CNT_W(27), .DIV_0(4), .DIV_1(6), .DIV_2(8), .DIV_3(10),
        .PC_W(PC_W), .ICNT_W(ICNT_W), .DEB_CYCLES(5)
    ) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .HALT(HALT), .STEP(STEP),
        .RATE_SEL(RATE_SEL), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .PC(PC),
        .CPU_EN(CPU_EN), .HB(HB), .STATE(STATE), .ICNT(ICNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        int                cyc;
        logic [ICNT_W-1:0] icnt;
        logic              hb;
    } exp_t;

    exp_t              exp_q[$];
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    int                base     = 0;
    logic [ICNT_W-1:0] m_icnt   = '0;
    logic              m_hb     = 1'b0;
    bit                pc_walk  = 1'b0;

    task automatic expect_pulse(input int at);
        exp_t e;
        m_icnt = m_icnt + 1'b1;
        m_hb   = ~m_hb;
        e.cyc  = at;
        e.icnt = m_icnt;
        e.hb   = m_hb;
        exp_q.push_back(e);
    endtask

    // Advance n cycles, sampling on the falling edge and scoring every tick.
    task automatic adv(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge SYS_CLK);
            cyc++;
            if (CPU_EN === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_cpu_en cyc=%0d icnt=%0d", cyc, ICNT);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || ICNT !== e.icnt || HB !== e.hb) begin
                        failures++;
                        $display("FAIL tick got cyc=%0d icnt=%0d hb=%0b want cyc=%0d icnt=%0d hb=%0b",
                                 cyc, ICNT, HB, e.cyc, e.icnt, e.hb);
                    end
                end
                if (pc_walk) PC = PC + 7'd4;
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_tick want cyc=%0d got none by cyc=%0d", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        adv(2);
        RST     = 1'b0;
        exp_q.delete();
        m_icnt  = '0;
        m_hb    = 1'b0;
        PC      = '0;
        pc_walk = 1'b0;
        base    = cyc;
    endtask

    task automatic test_reset();
        HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 0; BP_ADDR = '0;
        do_reset();
        checks++; if (STATE !== 2'b00) begin failures++; $display("FAIL reset_state got=%b want=00", STATE); end
        checks++; if (CPU_EN !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b want=0", CPU_EN); end
        checks++; if (HB !== 1'b0) begin failures++; $display("FAIL reset_hb got=%b want=0", HB); end
        checks++; if (ICNT !== '0) begin failures++; $display("FAIL reset_icnt got=%0d want=0", ICNT); end
    endtask

    task automatic test_rates();
        HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 0;
        do_reset();
        for (int k = 1; k <= 10; k++) expect_pulse(base + 4 * k);
        adv(40);
        checks++; if (ICNT !== 16'd10) begin failures++; $display("FAIL rate0_icnt got=%0d want=10", ICNT); end
        checks++; if (HB !== 1'b0) begin failures++; $display("FAIL rate0_hb got=%b want=0", HB); end
        RATE_SEL = 2'd3;
        for (int k = 1; k <= 4; k++) expect_pulse(base + 41 + 10 * k);
        adv(45);
        RATE_SEL = 2'd2;
        expect_pulse(base + 94);
        expect_pulse(base + 102);
        adv(17);
        checks++; if (ICNT !== 16'd16) begin failures++; $display("FAIL rate_icnt got=%0d want=16", ICNT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rate_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_halt();
        HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 0;
        do_reset();
        expect_pulse(base + 4);
        expect_pulse(base + 8);
        adv(11);
        HALT = 1;
        adv(1);
        checks++; if (STATE !== 2'b01) begin failures++; $display("FAIL halt_state got=%b want=01", STATE); end
        checks++; if (CPU_EN !== 1'b0) begin failures++; $display("FAIL halt_cpu_en got=%b want=0", CPU_EN); end
        adv(6);
        checks++; if (ICNT !== 16'd2) begin failures++; $display("FAIL halt_icnt got=%0d want=2", ICNT); end
        HALT = 0;
        adv(1);
        checks++; if (STATE !== 2'b00) begin failures++; $display("FAIL unhalt_state got=%b want=00", STATE); end
        expect_pulse(base + 23);
        expect_pulse(base + 27);
        adv(8);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL halt_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_step();
        int s;
        HALT = 1; STEP = 0; RATE_SEL = 0; BP_EN = 0;
        do_reset();
        adv(1);
        checks++; if (STATE !== 2'b01) begin failures++; $display("FAIL step_pre_state got=%b want=01", STATE); end
        adv(2);
        s = cyc;
        STEP = 1;
        expect_pulse(s + STEP_LAT);
        adv(STEP_LAT - 2);
        checks++; if (STATE !== 2'b01) begin failures++; $display("FAIL step_wait_state got=%b want=01", STATE); end
        adv(1);
        checks++; if (STATE !== 2'b10) begin failures++; $display("FAIL step_state got=%b want=10", STATE); end
        adv(1);
        checks++; if (STATE !== 2'b01) begin failures++; $display("FAIL step_post_state got=%b want=01", STATE); end
        adv(16);
        STEP = 0;
        adv(20);
        checks++; if (ICNT !== 16'd1) begin failures++; $display("FAIL step_icnt got=%0d want=1", ICNT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL step_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_breakpoint();
        int s;
        HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 1; BP_ADDR = 7'h0C;
        do_reset();
        pc_walk = 1;
        expect_pulse(base + 4);
        expect_pulse(base + 8);
        expect_pulse(base + 12);
        adv(16);
        checks++; if (STATE !== 2'b11) begin failures++; $display("FAIL bp_state got=%b want=11", STATE); end
        checks++; if (ICNT !== 16'd3) begin failures++; $display("FAIL bp_icnt got=%0d want=3", ICNT); end
        HALT = 1;
        adv(3);
        HALT = 0;
        adv(3);
        checks++; if (STATE !== 2'b11) begin failures++; $display("FAIL bp_hold_state got=%b want=11", STATE); end
        s = cyc;
        STEP = 1;
        expect_pulse(s + STEP_LAT);
        expect_pulse(s + STEP_LAT + 5);
        expect_pulse(s + STEP_LAT + 9);
        adv(6);
        STEP = 0;
        adv(STEP_LAT + 4);
        checks++; if (STATE !== 2'b00) begin failures++; $display("FAIL bp_resume_state got=%b want=00", STATE); end
        checks++; if (ICNT !== 16'd6) begin failures++; $display("FAIL bp_resume_icnt got=%0d want=6", ICNT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_pending got=%0d want=0", exp_q.size()); end
        pc_walk = 0;
    endtask

    task automatic test_bp_release();
        HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 1; BP_ADDR = 7'h04;
        do_reset();
        pc_walk = 1;
        expect_pulse(base + 4);
        adv(10);
        checks++; if (STATE !== 2'b11) begin failures++; $display("FAIL rel_break_state got=%b want=11", STATE); end
        BP_EN = 0;
        adv(1);
        checks++; if (STATE !== 2'b00) begin failures++; $display("FAIL rel_run_state got=%b want=00", STATE); end
        expect_pulse(base + 15);
        expect_pulse(base + 19);
        adv(8);
        BP_EN = 1; BP_ADDR = 7'h0C;
        adv(5);
        checks++; if (STATE !== 2'b11) begin failures++; $display("FAIL rel_break2_state got=%b want=11", STATE); end
        HALT = 1; BP_EN = 0;
        adv(1);
        checks++; if (STATE !== 2'b01) begin failures++; $display("FAIL rel_halt_state got=%b want=01", STATE); end
        HALT = 0;
        adv(1);
        checks++; if (STATE !== 2'b00) begin failures++; $display("FAIL rel_run2_state got=%b want=00", STATE); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rel_pending got=%0d want=0", exp_q.size()); end
        pc_walk = 0;
    endtask

    task automatic test_reset_mid();
        HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 1; BP_ADDR = 7'h14;
        do_reset();
        pc_walk = 1;
        for (int k = 1; k <= 5; k++) expect_pulse(base + 4 * k);
        adv(26);
        checks++; if (STATE !== 2'b11) begin failures++; $display("FAIL mid_state got=%b want=11", STATE); end
        checks++; if (ICNT !== 16'd5) begin failures++; $display("FAIL mid_icnt got=%0d want=5", ICNT); end
        checks++; if (HB !== 1'b1) begin failures++; $display("FAIL mid_hb got=%b want=1", HB); end
        RST = 1; BP_EN = 0;
        adv(1);
        checks++; if (STATE !== 2'b00) begin failures++; $display("FAIL rst_state got=%b want=00", STATE); end
        checks++; if (ICNT !== '0) begin failures++; $display("FAIL rst_icnt got=%0d want=0", ICNT); end
        checks++; if (HB !== 1'b0) begin failures++; $display("FAIL rst_hb got=%b want=0", HB); end
        checks++; if (CPU_EN !== 1'b0) begin failures++; $display("FAIL rst_cpu_en got=%b want=0", CPU_EN); end
        RST = 0;
        m_icnt = '0;
        m_hb = 1'b0;
        expect_pulse(cyc + 4);
        adv(4);
        checks++; if (ICNT !== 16'd1) begin failures++; $display("FAIL rst_first_icnt got=%0d want=1", ICNT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_pending got=%0d want=0", exp_q.size()); end
        pc_walk = 0;
    endtask

    task automatic test_step_glitch();
        int s;
        HALT = 1; STEP = 0; RATE_SEL = 0; BP_EN = 0;
        do_reset();
        adv(3);
        s = cyc;
        STEP = 1;
`ifndef RUN_CTRL_DEBOUNCE_EN
        expect_pulse(s + 4);
`endif
        adv(3);
        STEP = 0;
        adv(15);
`ifdef RUN_CTRL_DEBOUNCE_EN
        checks++; if (ICNT !== '0) begin failures++; $display("FAIL glitch_icnt got=%0d want=0", ICNT); end
        s = cyc;
        STEP = 1;
        expect_pulse(s + 9);
        adv(10);
        STEP = 0;
        adv(15);
`endif
        checks++; if (ICNT !== 16'd1) begin failures++; $display("FAIL glitch_step_icnt got=%0d want=1", ICNT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL glitch_pending got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        RST = 1; HALT = 0; STEP = 0; RATE_SEL = 0; BP_EN = 0; BP_ADDR = '0; PC = '0;
        test_reset();
        test_rates();
        test_halt();
        test_step();
        test_breakpoint();
        test_bp_release();
        test_reset_mid();
        test_step_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
